// File: rtl/uart_tx_param.sv
// ---------------------------------------------------------------------------
// uart_tx_param
//
// Parametrised RS-232 transmitter with a small input FIFO. Bit timing is
// taken from the shared baud generator's single-cycle Enable pulse; every
// bit lasts OVERSAMPLE Enable pulses. The word is sent LSB first, framed by
// one start bit, an optional parity bit and STOP_BITS stop bits.
//
// Parameters:
//   DATA_BITS  payload bits per frame (5..9)
//   PARITY     0 = none, 1 = even, 2 = odd
//   STOP_BITS  1 or 2
//   OVERSAMPLE Enable pulses per bit time (4..16)
//   FIFO_DEPTH queue entries, power of two (2..16)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   Enable     baud tick
//   TxD_valid  write request, accepted when TBR is high
//   TxD_data   word to queue
//   send_break break request (only with UART_TX_BREAK_EN defined)
//   TBR        FIFO not full
//   TxD        serial line, idles high
//   busy       frame in flight or FIFO non-empty
//   ovf        one-cycle pulse after a write was dropped on a full FIFO
//   fifo_cnt   FIFO occupancy
//
// Optional feature macro: UART_TX_BREAK_EN adds the send_break input and a
// BREAK state that holds the line low for at least one frame length.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | line high, waiting for a queued word (or a break request)
// S_START   | start bit, line low
// S_DATA    | payload bits, LSB first from the shift register
// S_PAR     | parity bit (only reached when PARITY != 0)
// S_STOP    | stop bits, line high; pops the next word back-to-back
// S_BREAK   | line held low while send_break is high, min one frame
// S_BRK_END | line high for STOP_BITS bit times after a break
// ---------------------------------------------------------------------------
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 2,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        Enable,
  input  logic                        TxD_valid,
  input  logic [DATA_BITS-1:0]        TxD_data,
`ifdef UART_TX_BREAK_EN
  input  logic                        send_break,
`endif
  output logic                        TBR,
  output logic                        TxD,
  output logic                        busy,
  output logic                        ovf,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = 4;

`ifdef UART_TX_BREAK_EN
  localparam int FRAME_LEN = OVERSAMPLE * (1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS);
  localparam int FW        = $clog2(FRAME_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK, S_BRK_END
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;
`endif

  // FIFO
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q;
  logic [PW-1:0]        rd_ptr_q;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic                 ovf_q;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  // FSM
  state_t               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [TW-1:0]        tick_q;
  logic [BW-1:0]        bit_q;
  logic                 par_q;
  logic                 txd_q;
  logic                 tick_end;
  logic                 stop_done;
  logic                 brk_req;

`ifdef UART_TX_BREAK_EN
  logic [FW-1:0]        brk_cnt_q;
  assign brk_req = send_break;
`else
  assign brk_req = 1'b0;
`endif

  // Full/empty come from the occupancy count, so TBR always reflects the
  // pre-edge state even when a pop happens on the same edge.
  assign fifo_empty = (cnt_q == '0);
  assign TBR        = (cnt_q != CW'(FIFO_DEPTH));
  assign push       = TxD_valid && TBR;
  assign head       = mem_q[rd_ptr_q];
  assign head_par   = (PARITY == 2) ? ~^head : ^head;

  assign tick_end  = (tick_q == TW'(OVERSAMPLE - 1));
  assign stop_done = (state_q == S_STOP) && Enable && tick_end &&
                     (bit_q == BW'(STOP_BITS - 1));
  // A break request in IDLE takes priority over starting a queued frame.
  assign pop       = !fifo_empty && (((state_q == S_IDLE) && !brk_req) || stop_done);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
      ovf_q <= TxD_valid && !TBR;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= TxD_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      tick_q    <= '0;
      bit_q     <= '0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
`ifdef UART_TX_BREAK_EN
      brk_cnt_q <= '0;
`endif
    end else if (pop) begin
      shift_q <= head;
      par_q   <= head_par;
      tick_q  <= '0;
      bit_q   <= '0;
      state_q <= S_START;
      txd_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          txd_q <= 1'b1;
`ifdef UART_TX_BREAK_EN
          if (send_break) begin
            state_q   <= S_BREAK;
            txd_q     <= 1'b0;
            brk_cnt_q <= '0;
          end
`endif
        end
        S_START: begin
          if (Enable) begin
            if (tick_end) begin
              tick_q  <= '0;
              state_q <= S_DATA;
              txd_q   <= shift_q[0];
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        S_DATA: begin
          if (Enable) begin
            if (tick_end) begin
              tick_q  <= '0;
              shift_q <= shift_q >> 1;
              if (bit_q == BW'(DATA_BITS - 1)) begin
                bit_q <= '0;
                if (PARITY != 0) begin
                  state_q <= S_PAR;
                  txd_q   <= par_q;
                end else begin
                  state_q <= S_STOP;
                  txd_q   <= 1'b1;
                end
              end else begin
                bit_q <= bit_q + BW'(1);
                txd_q <= shift_q[1];
              end
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        S_PAR: begin
          if (Enable) begin
            if (tick_end) begin
              tick_q  <= '0;
              state_q <= S_STOP;
              txd_q   <= 1'b1;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        S_STOP: begin
          // The back-to-back case is handled by the pop branch above.
          if (Enable) begin
            if (tick_end) begin
              tick_q <= '0;
              if (bit_q == BW'(STOP_BITS - 1)) begin
                bit_q   <= '0;
                state_q <= S_IDLE;
                txd_q   <= 1'b1;
              end else begin
                bit_q <= bit_q + BW'(1);
              end
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        S_BREAK: begin
          txd_q <= 1'b0;
          // brk_cnt_q saturates at FRAME_LEN; the break ends on the pulse
          // that completes the minimum length if the request is gone.
          if (brk_cnt_q == FW'(FRAME_LEN)) begin
            if (!send_break) begin
              state_q <= S_BRK_END;
              txd_q   <= 1'b1;
              tick_q  <= '0;
              bit_q   <= '0;
            end
          end else if (Enable) begin
            if ((brk_cnt_q == FW'(FRAME_LEN - 1)) && !send_break) begin
              state_q <= S_BRK_END;
              txd_q   <= 1'b1;
              tick_q  <= '0;
              bit_q   <= '0;
            end else begin
              brk_cnt_q <= brk_cnt_q + FW'(1);
            end
          end
        end
        S_BRK_END: begin
          txd_q <= 1'b1;
          if (Enable) begin
            if (tick_end) begin
              tick_q <= '0;
              if (bit_q == BW'(STOP_BITS - 1)) begin
                bit_q   <= '0;
                state_q <= S_IDLE;
              end else begin
                bit_q <= bit_q + BW'(1);
              end
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign TxD      = txd_q;
  assign ovf      = ovf_q;
  assign fifo_cnt = cnt_q;
  assign busy     = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_param
//
// Three transmitters with different parameter sets share one stimulus
// stream. A reference model tracks, per instance, a word queue and the
// position inside the current frame counted in Enable pulses; the expected
// line level is derived arithmetically from the frame layout.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_param;

  localparam int ND = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       valid;
  logic [8:0] data;
  logic       sb;

  logic [ND-1:0] txd_v;
  logic [ND-1:0] tbr_v;
  logic [ND-1:0] busy_v;
  logic [ND-1:0] ovf_v;
  logic [2:0]    fc0;
  logic [2:0]    fc1;
  logic [1:0]    fc2;

  always #5 clk = ~clk;

  uart_tx_param dut0 (
    .clk(clk), .rst(rst), .Enable(en), .TxD_valid(valid), .TxD_data(data[7:0]),
`ifdef UART_TX_BREAK_EN
    .send_break(sb),
`endif
    .TBR(tbr_v[0]), .TxD(txd_v[0]), .busy(busy_v[0]), .ovf(ovf_v[0]), .fifo_cnt(fc0)
  );

  uart_tx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .Enable(en), .TxD_valid(valid), .TxD_data(data[6:0]),
`ifdef UART_TX_BREAK_EN
    .send_break(sb),
`endif
    .TBR(tbr_v[1]), .TxD(txd_v[1]), .busy(busy_v[1]), .ovf(ovf_v[1]), .fifo_cnt(fc1)
  );

  uart_tx_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(4), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .Enable(en), .TxD_valid(valid), .TxD_data(data[6:0]),
`ifdef UART_TX_BREAK_EN
    .send_break(sb),
`endif
    .TBR(tbr_v[2]), .TxD(txd_v[2]), .busy(busy_v[2]), .ovf(ovf_v[2]), .fifo_cnt(fc2)
  );

  // Per-instance configuration
  function automatic int db_of(input int k);
    return (k == 0) ? 8 : 7;
  endfunction
  function automatic int par_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 2);
  endfunction
  function automatic int sb_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction
  function automatic int os_of(input int k);
    return (k == 2) ? 4 : 16;
  endfunction
  function automatic int depth_of(input int k);
    return (k == 2) ? 2 : 4;
  endfunction
  function automatic int flen(input int k);
    return os_of(k) * (1 + db_of(k) + ((par_of(k) != 0) ? 1 : 0) + sb_of(k));
  endfunction

  // Reference model state
  int         m_cnt  [ND];
  int         m_head [ND];
  int         m_inf  [ND];
  int         m_pidx [ND];
  int         m_brk  [ND];
  int         m_bn   [ND];
  logic [8:0] m_buf  [ND][16];
  logic [8:0] m_cur  [ND];
  logic       m_ovf  [ND];

  int n_checks = 0;
  int n_errors = 0;
  int ph = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line level of bit position bitn in a frame carrying word w.
  function automatic logic frame_bit(input int k, input logic [8:0] w, input int bitn);
    int db;
    db = db_of(k);
    if (bitn == 0) return 1'b0;
    if (bitn <= db) return w[bitn-1];
    if (par_of(k) != 0 && bitn == db + 1) return (par_of(k) == 1) ? ^w : ~^w;
    return 1'b1;
  endfunction

  function automatic logic exp_txd(input int k);
    if (m_brk[k] == 1) return 1'b0;
    if (m_brk[k] == 2) return 1'b1;
    if (m_inf[k] == 0) return 1'b1;
    return frame_bit(k, m_cur[k], m_pidx[k] / os_of(k));
  endfunction

  function automatic logic model_busy();
    logic b;
    b = 1'b0;
    for (int k = 0; k < ND; k++)
      if (m_inf[k] != 0 || m_cnt[k] != 0 || m_brk[k] != 0) b = 1'b1;
    return b;
  endfunction

  // Advances the model across one rising edge using the pre-edge inputs.
  task automatic model_edge();
    for (int k = 0; k < ND; k++) begin
      int  d;
      int  l;
      int  slot;
      int  n_new;
      bit  do_pop;
      bit  do_push;
      d = depth_of(k);
      l = flen(k);
      if (rst) begin
        m_cnt[k] = 0; m_head[k] = 0; m_inf[k] = 0; m_pidx[k] = 0;
        m_brk[k] = 0; m_bn[k] = 0; m_ovf[k] = 1'b0;
        continue;
      end
      m_ovf[k] = valid && (m_cnt[k] == d);
      do_push  = valid && (m_cnt[k] < d);
      slot     = (m_head[k] + m_cnt[k]) % d;
      do_pop   = 1'b0;
      if (m_brk[k] == 1) begin
        n_new = m_bn[k] + ((en && m_bn[k] < l) ? 1 : 0);
        if (!sb && n_new >= l) begin
          m_brk[k] = 2;
          m_bn[k]  = 0;
        end else begin
          m_bn[k] = n_new;
        end
      end else if (m_brk[k] == 2) begin
        if (en) begin
          m_bn[k]++;
          if (m_bn[k] == sb_of(k) * os_of(k)) m_brk[k] = 0;
        end
      end else if (m_inf[k] == 0) begin
        if (sb) begin
          m_brk[k] = 1;
          m_bn[k]  = 0;
        end else if (m_cnt[k] > 0) begin
          do_pop = 1'b1;
        end
      end else if (en) begin
        if (m_pidx[k] == l - 1) begin
          if (m_cnt[k] > 0) do_pop = 1'b1;
          else m_inf[k] = 0;
        end else begin
          m_pidx[k]++;
        end
      end
      if (do_pop) begin
        m_cur[k]  = m_buf[k][m_head[k]];
        m_head[k] = (m_head[k] + 1) % d;
        m_cnt[k]--;
        m_inf[k]  = 1;
        m_pidx[k] = 0;
      end
      if (do_push) begin
        m_buf[k][slot] = data & 9'((1 << db_of(k)) - 1);
        m_cnt[k]++;
      end
    end
  endtask

  function automatic logic [31:0] fc_of(input int k);
    if (k == 0) return 32'(fc0);
    if (k == 1) return 32'(fc1);
    return 32'(fc2);
  endfunction

  task automatic compare_all();
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("d%0d TxD", k),      32'(txd_v[k]),  32'(exp_txd(k)));
      chk($sformatf("d%0d TBR", k),      32'(tbr_v[k]),  32'(m_cnt[k] != depth_of(k)));
      chk($sformatf("d%0d busy", k),     32'(busy_v[k]), 32'(m_inf[k] != 0 || m_cnt[k] != 0 || m_brk[k] != 0));
      chk($sformatf("d%0d ovf", k),      32'(ovf_v[k]),  32'(m_ovf[k]));
      chk($sformatf("d%0d fifo_cnt", k), fc_of(k),       32'(m_cnt[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // One clock; Enable pulses every per clocks, per == 0 holds it low.
  task automatic cyc(input int per);
    if (per > 0) en = ((ph % per) == 0);
    else en = 1'b0;
    ph++;
    step();
  endtask

  task automatic run(input int n, input int per);
    for (int i = 0; i < n; i++) cyc(per);
  endtask

  task automatic put(input logic [8:0] w, input int per);
    valid = 1'b1;
    data  = w;
    cyc(per);
    valid = 1'b0;
  endtask

  task automatic drain(input int per, input int max_cyc);
    int n;
    n = 0;
    while (model_busy() && n < max_cyc) begin
      cyc(per);
      n++;
    end
    chk("drain", 32'(busy_v), 32'(0));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0; data = '0; sb = 1'b0;
    for (int k = 0; k < ND; k++) begin
      m_cnt[k] = 0; m_head[k] = 0; m_inf[k] = 0; m_pidx[k] = 0;
      m_brk[k] = 0; m_bn[k] = 0; m_ovf[k] = 1'b0; m_cur[k] = '0;
    end
    run(3, 1);
    rst = 1'b0;

    // single frames: A5 on defaults, 55 for the parity instances
    put(9'h0A5, 4);
    drain(4, 3000);
    put(9'h055, 4);
    drain(4, 3000);

    // Enable held low: six consecutive writes, then back-to-back frames
    for (int i = 0; i < 6; i++) put(9'($urandom), 0);
    run(5, 0);
    drain(1, 3000);

    // reset in the middle of DATA bit 3 of FF with two words queued
    put(9'h0FF, 1);
    put(9'($urandom), 1);
    put(9'($urandom), 1);
    run(16 + 3 * 16 + 5, 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    run(3, 1);
    put(9'h000, 1);
    drain(1, 3000);

    // long Enable stall in the middle of a frame
    put(9'($urandom), 2);
    run(60, 2);
    run(1000, 0);
    drain(2, 3000);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      valid = ($urandom_range(0, 5) == 0);
      data  = 9'($urandom);
      en    = ($urandom_range(0, 2) != 0);
      rst   = ($urandom_range(0, 1999) == 0);
      ph++;
      step();
    end
    valid = 1'b0;
    rst   = 1'b0;
    drain(1, 5000);

`ifdef UART_TX_BREAK_EN
    sb = 1'b1;
    run(10, 2);
    put(9'($urandom), 2);
    run(9, 2);
    sb = 1'b0;
    drain(2, 3000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised RS-232 transmitter; next generation of the mini_spart fixed 8N2 TX.
- Adds configurable data width, parity mode, stop-bit count and oversample ratio, plus a small input FIFO so the bus side can queue bytes.
- Sits between the SPART bus interface and the TxD pin.
- Bit timing comes from the shared baud generator's Enable pulse.

Parameters:
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 2, stop bits per frame; legal values 1 or 2.
- OVERSAMPLE, 16, Enable pulses per bit time; legal range 4..16.
- FIFO_DEPTH, 4, queue entries; power of two, 2..16.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- Enable  input  1  baud tick from the baud generator; single-cycle pulse.
- TxD_valid  input  1  write request.
- TxD_data  input  DATA_BITS  word to send; LSB is transmitted first.
- TBR  output  1  transmit buffer ready; high when the FIFO is not full.
- TxD  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- ovf  output  1  one-cycle pulse when TxD_valid is asserted while TBR is low.
- fifo_cnt  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst high at a clock edge):
  - FIFO is emptied and the FSM returns to IDLE.
  - Outputs: TxD=1, TBR=1, busy=0, ovf=0, fifo_cnt=0.
  - Reset asserted mid-frame aborts the frame; TxD is 1 on the following cycle.
- Write handshake:
  - A write occurs when TxD_valid && TBR. The word is stored and fifo_cnt increments on that same edge.
  - Writes when full are dropped, ovf pulses for one cycle, and FIFO contents are untouched.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: TxD=1. If the FIFO is non-empty, pop the head into the shift register, clear the tick and bit counters, and go to START. The pop is visible in fifo_cnt on the same edge.
  - START: TxD=0 for OVERSAMPLE Enable pulses, then go to DATA.
  - DATA: TxD=shift[0] for OVERSAMPLE Enable pulses per bit, shifting right after each bit. After DATA_BITS bits, go to PAR if PARITY!=0, otherwise go to STOP.
  - PAR: TxD=^word for even parity, ~^word for odd parity, held for one bit time; then go to STOP.
  - STOP: TxD=1 for STOP_BITS*OVERSAMPLE Enable pulses. If the FIFO is non-empty, pop and go straight to START (back-to-back, no idle gap); otherwise go to IDLE.
- Tick counter:
  - Counts only on cycles where Enable=1; it wraps at OVERSAMPLE-1, which ends the bit.
  - Enable held low stalls the frame indefinitely with TxD stable.
- Simultaneous events:
  - Write into an empty FIFO while in IDLE: the pop occurs on the next cycle (fifo_cnt goes 0→1→0).
  - Write and pop on the same edge: fifo_cnt is unchanged and both operations take effect.
  - Full FIFO with a pop on the same edge as TxD_valid: the write is still rejected, because TBR reflects the pre-edge state.
- busy = (state!=IDLE) || (fifo_cnt!=0), registered.
- Frame length in Enable pulses = OVERSAMPLE*(1+DATA_BITS+(PARITY!=0)+STOP_BITS); default 176.
- Pointer widths are $clog2(FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by fifo_cnt.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- When defined:
  - Extra input port send_break (1 bit).
  - send_break sampled high in IDLE enters BREAK state: TxD=0 while send_break stays high, with a minimum of one full frame length of Enable pulses.
  - On exit, TxD=1 for STOP_BITS bit times, then IDLE.
  - The FIFO still accepts writes during BREAK; busy=1.
  - send_break is ignored outside IDLE.
- When undefined: no send_break port, no BREAK state, and the logic is absent.

Test Plan:
- Defaults, Enable every 4 clocks, write 8'hA5 → TxD sequence 0,1,0,1,0,0,1,0,1,1,1, each bit 16 Enable pulses (64 clocks); busy low afterwards.
- PARITY=1, DATA_BITS=7, STOP_BITS=1, write 7'h55 → parity bit 0, frame 160 Enable pulses; PARITY=2 → parity bit 1.
- FIFO_DEPTH=4, Enable held low, 6 consecutive writes → first pops, then 4 fill; TBR low at fifo_cnt=4; ovf pulses exactly once on the 6th write; released Enable gives 5 back-to-back frames with no idle gap.
- rst asserted at DATA bit 3 of 8'hFF with 2 entries queued → next cycle TxD=1, fifo_cnt=0, busy=0; a new write of 8'h00 then transmits cleanly.
- Enable gated low for 1000 clocks mid-DATA → TxD constant; bit resumes and completes after the remaining pulses.
- UART_TX_BREAK_EN defined, send_break high for 10 Enable pulses → TxD low for 176 pulses, then high for 32 pulses, then IDLE.
